// File: rtl/spi_arb_pkg.sv
// spi_arb shared definitions
// Default sizing and FSM state encoding
package spi_arb_pkg;

  localparam int SPI_ARB_REQ_N    = 4;
  localparam int SPI_ARB_DATA_W   = 8;
  localparam int SPI_ARB_TMO_CLKS = 1024;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    HOLD  = 3'd4,
    REL   = 3'd5,
    RWAIT = 3'd6
  } spi_arb_state_t;

endpackage

// File: rtl/spi_rr_pick.sv
// Round-robin picker: first set request after ptr
// Combinational, reusable by other shared-peripheral arbiters
module spi_rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          vld
);

  int j;

  // scan ptr+1, ptr+2, ... with wrap; ptr itself is last
  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    j   = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!vld && req[j]) begin
        vld    = 1'b1;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/spi_arb.sv
// Shares one spi_master between REQ_N requesters
// Round-robin, CS-locked transactions, idle-timeout release
module spi_arb
  import spi_arb_pkg::*;
#(
  parameter int REQ_N    = SPI_ARB_REQ_N,
  parameter int DATA_W   = SPI_ARB_DATA_W,
  parameter int TMO_CLKS = SPI_ARB_TMO_CLKS
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [REQ_N-1:0]        req_i,
  input  logic [REQ_N*DATA_W-1:0] req_data_i,
  input  logic [REQ_N-1:0]        req_last_i,
  output logic [REQ_N-1:0]        ack_o,
  output logic [DATA_W-1:0]       rd_data_o,
  output logic [REQ_N-1:0]        gnt_o,
  output logic                    tmo_o,
  output logic                    spi_wr_o,
  output logic                    spi_csn_o,
  output logic [DATA_W-1:0]       spi_data_o,
  input  logic [DATA_W-1:0]       spi_data_i,
  input  logic                    spi_busy_i
);

  localparam int PW = $clog2(REQ_N);
  localparam int CW = $clog2(TMO_CLKS);

  spi_arb_state_t state;

  // ptr doubles as the owner index while gnt_o != 0
  logic [PW-1:0]    ptr;
  logic             lst;
  logic             wfirst;
  logic [CW-1:0]    cnt;
  logic [REQ_N-1:0] pk_gnt;
  logic [PW-1:0]    pk_idx;
  logic             pk_vld;

  spi_rr_pick #(
    .N  (REQ_N),
    .PW (PW)
  ) u_pick (
    .req (req_i),
    .ptr (ptr),
    .gnt (pk_gnt),
    .idx (pk_idx),
    .vld (pk_vld)
  );

  // arbitration FSM; outputs are loaded on entry to the state that shows them
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      ptr        <= PW'(REQ_N - 1);
      lst        <= 1'b0;
      wfirst     <= 1'b0;
      cnt        <= '0;
      ack_o      <= '0;
      gnt_o      <= '0;
      tmo_o      <= 1'b0;
      spi_wr_o   <= 1'b0;
      spi_csn_o  <= 1'b1;
      spi_data_o <= '0;
      rd_data_o  <= '0;
    end else begin
      ack_o    <= '0;
      tmo_o    <= 1'b0;
      spi_wr_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pk_vld) begin
            gnt_o      <= pk_gnt;
            ptr        <= pk_idx;
            lst        <= req_last_i[pk_idx];
            spi_wr_o   <= 1'b1;
            spi_csn_o  <= req_last_i[pk_idx];
            spi_data_o <= req_data_i[int'(pk_idx)*DATA_W +: DATA_W];
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          wfirst <= 1'b1;
          state  <= WAIT;
        end
        WAIT: begin
          if (wfirst) begin
            wfirst <= 1'b0;
          end else if (!spi_busy_i) begin
            rd_data_o <= spi_data_i;
            ack_o     <= gnt_o;
            state     <= DONE;
          end
        end
        DONE: begin
          cnt <= '0;
          if (lst) begin
            gnt_o <= '0;
            state <= IDLE;
          end else begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (req_i[ptr] && ack_o == '0) begin
            cnt        <= '0;
            lst        <= req_last_i[ptr];
            spi_wr_o   <= 1'b1;
            spi_csn_o  <= req_last_i[ptr];
            spi_data_o <= req_data_i[int'(ptr)*DATA_W +: DATA_W];
            state      <= ISSUE;
          end else if (cnt == CW'(TMO_CLKS - 1)) begin
            cnt        <= '0;
            spi_wr_o   <= 1'b1;
            spi_csn_o  <= 1'b1;
            spi_data_o <= '1;
            state      <= REL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REL: begin
          wfirst <= 1'b1;
          state  <= RWAIT;
        end
        RWAIT: begin
          if (wfirst) begin
            wfirst <= 1'b0;
          end else if (!spi_busy_i) begin
            tmo_o <= 1'b1;
            gnt_o <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arb.sv
// Directed self-checking bench for spi_arb
// Includes a small spi_master busy/echo model
module tb_spi_arb;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]         req;
  logic [N-1:0]         lst;
  logic [N-1:0][DW-1:0] dq;
  logic [N-1:0]         ack;
  logic [N-1:0]         gnt;
  logic [DW-1:0]        rd;
  logic [DW-1:0]        sdo;
  logic [DW-1:0]        sdi;
  logic [DW-1:0]        resp;
  logic                 tmo;
  logic                 wr;
  logic                 csn;
  logic                 busy;
  int                   blen;
  int                   bcnt;

  spi_arb #(
    .REQ_N    (N),
    .DATA_W   (DW),
    .TMO_CLKS (TMO)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .req_i      (req),
    .req_data_i (dq),
    .req_last_i (lst),
    .ack_o      (ack),
    .rd_data_o  (rd),
    .gnt_o      (gnt),
    .tmo_o      (tmo),
    .spi_wr_o   (wr),
    .spi_csn_o  (csn),
    .spi_data_o (sdo),
    .spi_data_i (sdi),
    .spi_busy_i (busy)
  );

  // spi_master stand-in: busy rises the cycle after wr, lasts blen cycles
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      bcnt <= 0;
      sdi  <= '0;
    end else if (wr) begin
      busy <= 1'b1;
      bcnt <= blen - 1;
      sdi  <= resp;
    end else if (busy) begin
      if (bcnt == 0) busy <= 1'b0;
      else bcnt <= bcnt - 1;
    end
  end

  int         ack_q[$];
  int         ack_c[$];
  logic [7:0] rd_q[$];
  int         wr_c[$];
  logic [7:0] wr_d[$];
  logic       wr_cs[$];
  int         tmo_n;
  int         tmo_c;
  logic [7:0] tmo_rd;
  logic [3:0] tmo_g;
  int         left[N];
  int         cyc;
  int         checks;
  int         errors;
  int         t0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (wr) begin
      wr_d.push_back(sdo);
      wr_cs.push_back(csn);
      wr_c.push_back(cyc);
    end
    if (tmo) begin
      tmo_n++;
      tmo_c  = cyc;
      tmo_rd = rd;
      tmo_g  = gnt;
    end
    for (int i = 0; i < N; i++) begin
      if (ack[i]) begin
        ack_q.push_back(i);
        ack_c.push_back(cyc);
        rd_q.push_back(rd);
        if (left[i] > 1) begin
          left[i]--;
          dq[i]  = dq[i] + 8'd1;
          lst[i] = (left[i] == 1);
        end else begin
          left[i] = 0;
          req[i]  = 1'b0;
        end
      end
    end
  endtask

  task automatic post(input int i, input logic [7:0] d,
                      input int n, input logic l);
    dq[i]   = d;
    lst[i]  = l;
    left[i] = n;
    req[i]  = 1'b1;
  endtask

  task automatic clrq();
    ack_q.delete();
    ack_c.delete();
    rd_q.delete();
    wr_c.delete();
    wr_d.delete();
    wr_cs.delete();
    tmo_n = 0;
  endtask

  task automatic wait_acks(input int n, input int bound);
    int k;
    k = 0;
    while (ack_q.size() < n && k < bound) begin
      step();
      k++;
    end
    chk("ack_count", ack_q.size(), n);
  endtask

  task automatic do_reset();
    req = '0;
    for (int i = 0; i < N; i++) left[i] = 0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    int e3[4];
    req = '0;
    lst = '0;
    dq = '0;
    blen = 3;
    resp = 8'h3C;
    cyc = 0;
    checks = 0;
    errors = 0;
    tmo_n = 0;
    tmo_c = 0;
    tmo_rd = '0;
    tmo_g = '0;
    for (int i = 0; i < N; i++) left[i] = 0;

    // reset state
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_wr_tmo", 32'({wr, tmo}), 0);
    chk("rst_csn", 32'(csn), 1);
    chk("rst_sdo", 32'(sdo), 0);
    chk("rst_rd", 32'(rd), 0);

    // single request, busy 3 cycles
    clrq();
    t0 = cyc;
    post(0, 8'hA5, 1, 1'b1);
    wait_acks(1, 50);
    chk("t1_wr_cyc", wr_c[0] - t0, 1);
    chk("t1_wr_data", 32'(wr_d[0]), 32'hA5);
    chk("t1_wr_csn", 32'(wr_cs[0]), 1);
    chk("t1_ack_who", ack_q[0], 0);
    chk("t1_ack_cyc", ack_c[0] - t0, 6);
    chk("t1_rd", 32'(rd_q[0]), 32'h3C);
    step();
    chk("t1_gnt_free", 32'(gnt), 0);

    // long busy: ack exactly one cycle after busy falls
    clrq();
    blen = 40;
    resp = 8'hC3;
    t0 = cyc;
    post(2, 8'h5A, 1, 1'b1);
    wait_acks(1, 100);
    chk("t5_ack_who", ack_q[0], 2);
    chk("t5_ack_cyc", ack_c[0] - t0, 43);
    chk("t5_rd", 32'(rd_q[0]), 32'hC3);

    // contention from reset
    do_reset();
    clrq();
    blen = 1;
    resp = 8'h3C;
    for (int i = 0; i < N; i++) post(i, 8'(8'h10 + i), 1, 1'b1);
    wait_acks(4, 200);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("t2_order%0d", i), ack_q[i], i);
      chk($sformatf("t2_data%0d", i), 32'(wr_d[i]), 32'h10 + i);
    end
    clrq();
    post(0, 8'h01, 1, 1'b1);
    post(2, 8'h02, 1, 1'b1);
    wait_acks(2, 100);
    chk("t2_re_first", ack_q[0], 0);
    chk("t2_re_second", ack_q[1], 2);

    // CS lock: requester 1 three words, requester 2 waiting
    clrq();
    post(1, 8'h20, 3, 1'b0);
    post(2, 8'h30, 1, 1'b1);
    wait_acks(4, 300);
    e3 = '{1, 1, 1, 2};
    for (int i = 0; i < 4; i++)
      chk($sformatf("t3_ack%0d", i), ack_q[i], e3[i]);
    chk("t3_csn", 32'({wr_cs[0], wr_cs[1], wr_cs[2], wr_cs[3]}), 32'b0011);
    chk("t3_d1", 32'(wr_d[1]), 32'h21);
    chk("t3_d2", 32'(wr_d[2]), 32'h22);
    chk("t3_d3", 32'(wr_d[3]), 32'h30);
    chk("t3_gap", wr_c[1] - ack_c[0], 2);

    // timeout: owner stops after a non-last word
    clrq();
    resp = 8'h99;
    post(0, 8'h40, 1, 1'b0);
    step();
    step();
    post(3, 8'h50, 1, 1'b1);
    wait_acks(1, 50);
    resp = 8'h66;
    wait_acks(2, 200);
    chk("t4_ack0", ack_q[0], 0);
    chk("t4_rd0", 32'(rd_q[0]), 32'h99);
    chk("t4_rel_data", 32'(wr_d[1]), 32'hFF);
    chk("t4_rel_csn", 32'(wr_cs[1]), 1);
    chk("t4_rel_cyc", wr_c[1] - ack_c[0], 17);
    chk("t4_tmo_n", tmo_n, 1);
    chk("t4_tmo_cyc", tmo_c - ack_c[0], 20);
    chk("t4_tmo_rd", 32'(tmo_rd), 32'h99);
    chk("t4_tmo_gnt", 32'(tmo_g), 0);
    chk("t4_next_who", ack_q[1], 3);
    chk("t4_next_data", 32'(wr_d[2]), 32'h50);
    chk("t4_next_rd", 32'(rd_q[1]), 32'h66);

    // reset in the middle of WAIT
    clrq();
    blen = 40;
    post(1, 8'h77, 1, 1'b1);
    repeat (4) step();
    chk("t6_pre_gnt", 32'(gnt), 32'b0010);
    req = '0;
    for (int i = 0; i < N; i++) left[i] = 0;
    rst_n = 1'b0;
    step();
    chk("t6_gnt", 32'(gnt), 0);
    chk("t6_csn", 32'(csn), 1);
    chk("t6_sdo", 32'(sdo), 0);
    chk("t6_rd", 32'(rd), 0);
    chk("t6_pulses", 32'({ack, wr, tmo}), 0);
    step();
    rst_n = 1'b1;
    step();
    clrq();
    blen = 1;
    post(0, 8'h0A, 1, 1'b1);
    post(3, 8'h0B, 1, 1'b1);
    wait_acks(1, 50);
    chk("t6_first", ack_q[0], 0);
    chk("t6_first_data", 32'(wr_d[0]), 32'h0A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
